// File: rtl/toi2s_pkg.sv
// Shared types and default sizing for the toi2s PWM block and its register-bank field.
package toi2s_pkg;

  localparam int PWM_N_CH       = 2;
  localparam int PWM_WIDTH      = 8;
  localparam int PWM_PRESCALE_W = 4;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

  // sys_cfg fields that feed the PWM block
  typedef struct packed {
    logic [PWM_N_CH*PWM_WIDTH-1:0] duty;
    logic [PWM_WIDTH-1:0]          period;
    logic [PWM_PRESCALE_W-1:0]     prescale;
    pwm_mode_e                     mode;
  } sys_cfg_t;

endpackage

// File: rtl/pwm_multi_if.sv
// Configuration/request inputs and PWM outputs of pwm_multi, plus counter debug taps.
interface pwm_multi_if
  import toi2s_pkg::*;
#(
  parameter int N_CH       = PWM_N_CH,
  parameter int WIDTH      = PWM_WIDTH,
  parameter int PRESCALE_W = PWM_PRESCALE_W
);
  logic                    ena;
  logic                    center_mode;
  logic [WIDTH-1:0]        period;
  logic [PRESCALE_W-1:0]   prescale;
  logic [N_CH*WIDTH-1:0]   duty;
  // duty_load is a one-cycle request with no stall; load_ack is a one-cycle
  // completion pulse when the requested duty becomes active at a boundary.
  logic                    duty_load;
  logic [N_CH-1:0]         pwm_out;
  logic                    period_start;
  logic                    load_ack;
  logic [WIDTH-1:0]        dbg_cnt;
  pwm_dir_e                dbg_dir;

  modport master (
    output ena, center_mode, period, prescale, duty, duty_load,
    input  pwm_out, period_start, load_ack, dbg_cnt, dbg_dir
  );

  modport slave (
    input  ena, center_mode, period, prescale, duty, duty_load,
    output pwm_out, period_start, load_ack, dbg_cnt, dbg_dir
  );
endinterface

// File: rtl/pwm_multi_prescaler.sv
// Clock divider: one tick every prescale+1 cycles; clear restarts the count.
module pwm_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] count;

  // >= keeps the divider from running away if prescale shrinks mid-count
  assign tick = !clear && (count >= prescale);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count <= '0;
    end else if (clear || count >= prescale) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned counter, double-buffered per-channel duty.
module pwm_multi
  import toi2s_pkg::*;
#(
  parameter int N_CH       = PWM_N_CH,
  parameter int WIDTH      = PWM_WIDTH,
  parameter int PRESCALE_W = PWM_PRESCALE_W
) (
  input logic        clk,
  input logic        resetb,
  pwm_multi_if.slave bus
);
  logic [WIDTH-1:0]            cnt;
  logic [WIDTH-1:0]            cnt_nx;
  logic [WIDTH-1:0]            period_q;
  pwm_dir_e                    dir;
  pwm_dir_e                    dir_nx;
  pwm_mode_e                   mode_q;
  logic [N_CH-1:0][WIDTH-1:0]  duty_act;
  logic [N_CH-1:0][WIDTH-1:0]  staging;
  logic                        pending;
  logic                        ena_q;
  logic                        tick;
  logic                        start;
  logic                        presc_clear;
  logic                        eff_center;
  logic                        wrap;
  logic                        boundary;
  logic [N_CH-1:0]             cmp;
  logic [N_CH-1:0]             pwm_q;
  logic                        period_start_q;
  logic                        load_ack_q;

  assign start       = bus.ena && !ena_q;
  assign presc_clear = !bus.ena || start;

  pwm_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .resetb   (resetb),
    .clear    (presc_clear),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  // Next count on a tick; wrap marks the tick that would load cnt=0
  always_comb begin
    eff_center = (mode_q == PWM_CENTER) && (period_q != '0);
    cnt_nx     = cnt + 1'b1;
    dir_nx     = dir;
    wrap       = 1'b0;
    if (!eff_center) begin
      if (cnt == period_q) begin
        cnt_nx = '0;
        wrap   = 1'b1;
      end
    end else if (dir == DIR_UP) begin
      if (cnt == period_q) begin
        cnt_nx = cnt - 1'b1;
        dir_nx = DIR_DOWN;
        wrap   = (period_q == WIDTH'(1));
      end
    end else begin
      cnt_nx = cnt - 1'b1;
      wrap   = (cnt == WIDTH'(1));
    end
  end

  assign boundary = start || (tick && wrap);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign cmp[k] = (cnt < duty_act[k]);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt            <= '0;
      dir            <= DIR_UP;
      period_q       <= '0;
      mode_q         <= PWM_EDGE;
      duty_act       <= '0;
      staging        <= '0;
      pending        <= 1'b0;
      ena_q          <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      load_ack_q     <= 1'b0;
    end else begin
      period_start_q <= 1'b0;
      load_ack_q     <= 1'b0;
      pwm_q          <= bus.ena ? cmp : '0;
      ena_q          <= bus.ena;
      if (!bus.ena) begin
        cnt <= '0;
        dir <= DIR_UP;
      end else if (boundary) begin
        cnt            <= '0;
        dir            <= DIR_UP;
        period_q       <= bus.period;
        mode_q         <= pwm_mode_e'(bus.center_mode);
        period_start_q <= 1'b1;
        if (pending || bus.duty_load) begin
          duty_act   <= bus.duty_load ? bus.duty : staging;
          pending    <= 1'b0;
          load_ack_q <= 1'b1;
        end
      end else if (tick) begin
        cnt <= cnt_nx;
        dir <= dir_nx;
      end
      // Requests away from a boundary are staged; last write wins
      if (bus.duty_load && !boundary) begin
        staging <= bus.duty;
        pending <= 1'b1;
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.load_ack     = load_ack_q;
  assign bus.dbg_cnt      = cnt;
  assign bus.dbg_dir      = dir;
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed scenarios plus random runs against a position-in-period model.
module tb_pwm_multi;
  import toi2s_pkg::*;

  localparam int N_CH  = PWM_N_CH;
  localparam int WIDTH = PWM_WIDTH;
  localparam int PW    = PWM_PRESCALE_W;
  localparam int EW    = N_CH + 3 + WIDTH;

  // clock / reset
  logic clk    = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH), .PRESCALE_W(PW)) bus ();

  pwm_multi #(.N_CH(N_CH), .WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model: position within the current period, in ticks
  int m_pos, m_p, m_cyc;
  bit m_center, m_run, m_pending;
  int m_act[N_CH];
  int m_stage[N_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int per_len(int p, bit c);
    return (c && p > 0) ? 2 * p : p + 1;
  endfunction

  function automatic int cnt_at(int pos, int p, bit c);
    return (c && p > 0 && pos > p) ? 2 * p - pos : pos;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_p = 0; m_cyc = 0;
    m_center = 0; m_run = 0; m_pending = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_act[k]   = 0;
      m_stage[k] = 0;
    end
  endtask

  // Called at the active edge with the inputs the DUT is sampling
  task automatic model_step();
    logic [N_CH-1:0] pwm;
    bit ps, la, bnd, dn;
    int c;
    c  = cnt_at(m_pos, m_p, m_center);
    for (int k = 0; k < N_CH; k++) pwm[k] = bus.ena && (c < m_act[k]);
    ps  = 0;
    la  = 0;
    bnd = 0;
    if (!bus.ena) begin
      m_run = 0;
      m_pos = 0;
    end else begin
      if (!m_run) begin
        m_cyc = 0;
        bnd   = 1;
      end else begin
        m_cyc++;
        if ((m_cyc % (int'(bus.prescale) + 1)) == 0) begin
          m_pos++;
          if (m_pos == per_len(m_p, m_center)) bnd = 1;
        end
      end
      m_run = 1;
    end
    if (bnd) begin
      m_pos    = 0;
      m_p      = int'(bus.period);
      m_center = bus.center_mode;
      ps       = 1;
      if (m_pending || bus.duty_load) begin
        for (int k = 0; k < N_CH; k++)
          m_act[k] = bus.duty_load ? int'(bus.duty[k*WIDTH +: WIDTH]) : m_stage[k];
        m_pending = 0;
        la        = 1;
      end
    end else if (bus.duty_load) begin
      for (int k = 0; k < N_CH; k++) m_stage[k] = int'(bus.duty[k*WIDTH +: WIDTH]);
      m_pending = 1;
    end
    dn = m_center && (m_p > 0) && (m_pos > m_p);
    exp_q.push_back({dn, WIDTH'(cnt_at(m_pos, m_p, m_center)), la, ps, pwm});
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check("pwm_out", bus.pwm_out, e[N_CH-1:0]);
    check("period_start", bus.period_start, e[N_CH]);
    check("load_ack", bus.load_ack, e[N_CH+1]);
    check("cnt", bus.dbg_cnt, e[N_CH+2 +: WIDTH]);
    check("dir", bus.dbg_dir, e[EW-1]);
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic apply_cfg(input sys_cfg_t cfg);
    bus.duty        = cfg.duty;
    bus.period      = cfg.period;
    bus.prescale    = cfg.prescale;
    bus.center_mode = (cfg.mode == PWM_CENTER);
  endtask

  // Disable for a cycle, then enable with an immediate duty load on the start boundary
  task automatic restart(input sys_cfg_t cfg);
    bus.ena = 1'b0;
    apply_cfg(cfg);
    cycle();
    bus.ena       = 1'b1;
    bus.duty_load = 1'b1;
    cycle();
    bus.duty_load = 1'b0;
    cycle();
  endtask

  task automatic run_count(input int n, output int h0, output int h1, output int ps, output int la);
    h0 = 0; h1 = 0; ps = 0; la = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      h0 += int'(bus.pwm_out[0]);
      h1 += int'(bus.pwm_out[1]);
      ps += int'(bus.period_start);
      la += int'(bus.load_ack);
    end
  endtask

  task automatic do_reset();
    #2 resetb = 1'b0;
    #1;
    check("rst_pwm_out", bus.pwm_out, 0);
    check("rst_period_start", bus.period_start, 0);
    check("rst_load_ack", bus.load_ack, 0);
    check("rst_cnt", bus.dbg_cnt, 0);
    model_reset();
    @(negedge clk);
    resetb = 1'b1;
  endtask

  function automatic logic [N_CH*WIDTH-1:0] rand_duty();
    logic [N_CH*WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < N_CH; k++) begin
      case ($urandom_range(0, 5))
        0:       d[k*WIDTH +: WIDTH] = '0;
        1:       d[k*WIDTH +: WIDTH] = '1;
        default: d[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 14));
      endcase
    end
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] rand_period();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return WIDTH'(1);
      2:       return WIDTH'(254);
      default: return WIDTH'($urandom_range(2, 12));
    endcase
  endfunction

  sys_cfg_t cfg;
  int h0, h1, ps, la;

  initial begin
    bus.ena = 1'b0; bus.center_mode = 1'b0; bus.period = '0;
    bus.prescale = '0; bus.duty = '0; bus.duty_load = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_pwm_out", bus.pwm_out, 0);
    check("reset_cnt", bus.dbg_cnt, 0);
    resetb = 1'b1;

    // edge mode, period 9, duty {3,7}
    cfg = '{duty: {8'd7, 8'd3}, period: 8'd9, prescale: 4'd0, mode: PWM_EDGE};
    restart(cfg);
    run_count(10, h0, h1, ps, la);
    check("edge_ch0_high", h0, 3);
    check("edge_ch1_high", h1, 7);
    check("edge_period_start", ps, 1);

    // center mode, period 4, duty {5,2}
    cfg = '{duty: {8'd5, 8'd2}, period: 8'd4, prescale: 4'd0, mode: PWM_CENTER};
    restart(cfg);
    run_count(8, h0, h1, ps, la);
    check("center_ch0_high", h0, 3);
    check("center_ch1_high", h1, 8);
    check("center_period_start", ps, 1);

    // prescale 3, period 3, duty {1,4}
    cfg = '{duty: {8'd1, 8'd4}, period: 8'd3, prescale: 4'd3, mode: PWM_EDGE};
    restart(cfg);
    run_count(16, h0, h1, ps, la);
    check("presc_ch0_high", h0, 16);
    check("presc_ch1_high", h1, 4);
    check("presc_period_start", ps, 1);

    // staged loads mid-period: 5 then 6, last write wins at the boundary
    cfg = '{duty: {8'd2, 8'd2}, period: 8'd9, prescale: 4'd0, mode: PWM_EDGE};
    restart(cfg);
    repeat (2) cycle();
    bus.duty = {8'd2, 8'd5}; bus.duty_load = 1'b1; cycle(); bus.duty_load = 1'b0;
    repeat (2) cycle();
    bus.duty = {8'd2, 8'd6}; bus.duty_load = 1'b1; cycle(); bus.duty_load = 1'b0;
    bus.duty = {8'd2, 8'd1};
    run_count(4, h0, h1, ps, la);
    check("staged_load_ack", la, 1);
    cycle();
    run_count(10, h0, h1, ps, la);
    check("staged_ch0_high", h0, 6);
    check("staged_no_ack", la, 0);

    // period 254: duty 255 constant high, duty 0 constant low
    cfg = '{duty: {8'd0, 8'd255}, period: 8'd254, prescale: 4'd0, mode: PWM_EDGE};
    restart(cfg);
    run_count(255, h0, h1, ps, la);
    check("full_ch0_high", h0, 255);
    check("zero_ch1_high", h1, 0);

    // ena drop mid-period with a load pending, then reset discards it
    bus.duty = {8'd9, 8'd9}; bus.duty_load = 1'b1; cycle(); bus.duty_load = 1'b0;
    cycle();
    bus.ena = 1'b0;
    cycle();
    check("ena_low_pwm", bus.pwm_out, 0);
    do_reset();
    bus.ena = 1'b1;
    run_count(20, h0, h1, ps, la);
    check("post_rst_ch0", h0, 0);
    check("post_rst_ch1", h1, 0);
    check("post_rst_ack", la, 0);

    // random runs; prescale only changes while disabled
    for (int s = 0; s < 25; s++) begin
      bus.ena = 1'b0;
      bus.prescale = PW'($urandom_range(0, 3));
      bus.period = rand_period();
      bus.center_mode = 1'($urandom_range(0, 1));
      bus.duty = rand_duty();
      cycle();
      bus.ena = 1'b1;
      bus.duty_load = 1'($urandom_range(0, 1));
      for (int i = 0; i < 150; i++) begin
        cycle();
        bus.duty_load = ($urandom_range(0, 9) == 0);
        if (bus.duty_load) bus.duty = rand_duty();
        if ($urandom_range(0, 19) == 0) begin
          bus.period = rand_period();
          bus.center_mode = 1'($urandom_range(0, 1));
        end
        bus.ena = ($urandom_range(0, 49) != 0);
      end
      if (s % 8 == 7) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
